// File: rtl/ram_bus_arbiter.sv
// Shares one RAM port among NCPU icaches and dcaches: dcache requests win,
// round-robin within each class, and a grant is held across a block transfer.
module ram_bus_arbiter #(
    parameter int unsigned NCPU      = 2,
    parameter int unsigned MAX_BEATS = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NCPU-1:0]    iREN,
    input  logic [NCPU*32-1:0] iaddr,
    input  logic [NCPU-1:0]    dREN,
    input  logic [NCPU-1:0]    dWEN,
    input  logic [NCPU*32-1:0] daddr,
    input  logic [NCPU*32-1:0] dstore,
    output logic [NCPU-1:0]    iwait,
    output logic [NCPU-1:0]    dwait,
    output logic [NCPU*32-1:0] iload,
    output logic [NCPU*32-1:0] dload,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [31:0]        ramaddr,
    output logic [31:0]        ramstore,
    input  logic [31:0]        ramload,
    input  logic [1:0]         ramstate,
    output logic               bus_err
);

    localparam int unsigned IDX_W  = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int unsigned BEAT_W = 4;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [BEAT_W-1:0] BEAT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic [IDX_W-1:0]  d_rr_q, d_rr_d;
    logic [IDX_W-1:0]  i_rr_q, i_rr_d;
    logic              bus_err_q, bus_err_d;

    logic [NCPU-1:0]   d_req;
    logic              own_req;
    logic              beat;
    logic [BEAT_W:0]   beats_inc;
    logic              last_beat;
    logic              release_grant;

    // First requester at or after ptr, searching cyclically.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NCPU-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NCPU; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NCPU) begin
                idx = idx - NCPU;
            end
            if (!found && req[IDX_W'(idx)]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (32'(idx) + 32'd1 >= NCPU) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

    assign d_req     = dREN | dWEN;
    assign beat      = (state_q != IDLE) && (ramstate == RAM_ACCESS);
    assign beats_inc = {1'b0, beats_q} + (BEAT_W+1)'(1);
    assign last_beat = (beats_inc == (BEAT_W+1)'(MAX_BEATS));
    assign bus_err   = bus_err_q;

    always_comb begin
        own_req = 1'b0;
        case (state_q)
            DGRANT:  own_req = d_req[owner_q];
            IGRANT:  own_req = iREN[owner_q];
            default: own_req = 1'b0;
        endcase
    end

    assign release_grant = (state_q != IDLE) && (!own_req || (beat && last_beat));

    // RAM drive and per-core waits follow the current grant combinationally.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DGRANT: begin
                ramWEN   = dWEN[owner_q];
                ramREN   = dREN[owner_q] & ~dWEN[owner_q];
                ramaddr  = daddr[32'(owner_q)*32 +: 32];
                ramstore = dstore[32'(owner_q)*32 +: 32];
                dwait[owner_q] = ~beat;
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[32'(owner_q)*32 +: 32];
                iwait[owner_q] = ~beat;
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < NCPU; g++) begin : g_load
        assign iload[g*32 +: 32] = ramload;
        assign dload[g*32 +: 32] = ramload;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        beats_d   = beats_q;
        d_rr_d    = d_rr_q;
        i_rr_d    = i_rr_q;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE: begin
                if (|d_req) begin
                    state_d = DGRANT;
                    owner_d = rr_pick(d_req, d_rr_q);
                end else if (|iREN) begin
                    state_d = IGRANT;
                    owner_d = rr_pick(iREN, i_rr_q);
                end
            end
            DGRANT, IGRANT: begin
                if (ramstate == RAM_ERROR) begin
                    bus_err_d = 1'b1;
                end
                if (release_grant) begin
                    state_d = IDLE;
                    beats_d = '0;
                    if (state_q == DGRANT) begin
                        d_rr_d = next_idx(owner_q);
                    end else begin
                        i_rr_d = next_idx(owner_q);
                    end
                end else if (beat && (beats_q != BEAT_SAT)) begin
                    beats_d = beats_inc[BEAT_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            beats_q   <= '0;
            d_rr_q    <= '0;
            i_rr_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            beats_q   <= beats_d;
            d_rr_q    <= d_rr_d;
            i_rr_q    <= i_rr_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: directed vector table, hand sequences, and
// random traffic against a cycle-level model of the arbitration rules.
module tb_ram_bus_arbiter;

    localparam int NCPU = 2;
    localparam int MAXB = 2;

    logic        CLK;
    logic        RST;
    logic [1:0]  iREN, dREN, dWEN;
    logic [63:0] iaddr, daddr, dstore;
    logic [1:0]  iwait, dwait;
    logic [63:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_st, m_own, m_beats, m_drr, m_irr;
    bit m_err;

    ram_bus_arbiter #(.NCPU(NCPU), .MAX_BEATS(MAXB)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  iren, dren, dwen;
        logic [31:0] da0, da1, ds1;
        logic [1:0]  rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] req, input int ptr);
        for (int k = 0; k < NCPU; k++) begin
            if (req[(ptr + k) % NCPU]) return (ptr + k) % NCPU;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m_st = 0; m_own = 0; m_beats = 0; m_drr = 0; m_irr = 0; m_err = 0;
    endtask

    // Compare all outputs against what the model says for the current cycle
    task automatic model_check();
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic [1:0]  e_iw, e_dw;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_iw = 2'b11; e_dw = 2'b11;
        if (m_st == 1) begin
            e_wen   = dWEN[m_own];
            e_ren   = dREN[m_own] && !dWEN[m_own];
            e_addr  = daddr[m_own*32 +: 32];
            e_store = dstore[m_own*32 +: 32];
            if (ramstate == 2'd2) e_dw[m_own] = 1'b0;
        end else if (m_st == 2) begin
            e_ren  = 1'b1;
            e_addr = iaddr[m_own*32 +: 32];
            if (ramstate == 2'd2) e_iw[m_own] = 1'b0;
        end
        chk("ramREN", 32'(ramREN), 32'(e_ren));
        chk("ramWEN", 32'(ramWEN), 32'(e_wen));
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("iwait", 32'(iwait), 32'(e_iw));
        chk("dwait", 32'(dwait), 32'(e_dw));
        chk("bus_err", 32'(bus_err), 32'(m_err));
        for (int i = 0; i < NCPU; i++) begin
            chk("iload", iload[i*32 +: 32], ramload);
            chk("dload", dload[i*32 +: 32], ramload);
        end
    endtask

    // Advance the model across one rising edge using this cycle's inputs
    task automatic tick();
        int         n_st, n_own, n_beats, n_drr, n_irr;
        bit         n_err, req, beat;
        logic [1:0] dreq;
        n_st = m_st; n_own = m_own; n_beats = m_beats;
        n_drr = m_drr; n_irr = m_irr; n_err = m_err;
        dreq = dREN | dWEN;
        if (m_st == 0) begin
            if (dreq != 0) begin
                n_st = 1; n_own = pick(dreq, m_drr);
            end else if (iREN != 0) begin
                n_st = 2; n_own = pick(iREN, m_irr);
            end
        end else begin
            req  = (m_st == 1) ? dreq[m_own] : iREN[m_own];
            beat = (ramstate == 2'd2);
            if (ramstate == 2'd3) n_err = 1;
            if (!req || (beat && m_beats + 1 == MAXB)) begin
                n_st = 0; n_beats = 0;
                if (m_st == 1) n_drr = (m_own + 1) % NCPU;
                else           n_irr = (m_own + 1) % NCPU;
            end else if (beat) begin
                n_beats = (m_beats < 15) ? m_beats + 1 : 15;
            end
        end
        @(posedge CLK);
        m_st = n_st; m_own = n_own; m_beats = n_beats;
        m_drr = n_drr; m_irr = n_irr; m_err = n_err;
        #1;
    endtask

    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        model_check();
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge CLK);
        #1;
        model_check();
        RST = 1'b0;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramstate = 2'd0; ramload = 32'h0;
    endtask

    initial begin
        // iren dren dwen da0 da1 ds1 rs | ren wen addr store iw dw
        tbl[0]  = '{2'b00, 2'b01, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0,   32'h0, 2'b11, 2'b11};
        tbl[1]  = '{2'b00, 2'b01, 2'b00, 32'h40, 32'h80, 32'h0, 2'd1, 1'b1, 1'b0, 32'h40,  32'h0, 2'b11, 2'b11};
        tbl[2]  = '{2'b00, 2'b01, 2'b00, 32'h40, 32'h80, 32'h0, 2'd2, 1'b1, 1'b0, 32'h40,  32'h0, 2'b11, 2'b10};
        tbl[3]  = '{2'b00, 2'b01, 2'b00, 32'h44, 32'h80, 32'h0, 2'd1, 1'b1, 1'b0, 32'h44,  32'h0, 2'b11, 2'b11};
        tbl[4]  = '{2'b00, 2'b01, 2'b00, 32'h44, 32'h80, 32'h0, 2'd2, 1'b1, 1'b0, 32'h44,  32'h0, 2'b11, 2'b10};
        tbl[5]  = '{2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0,   32'h0, 2'b11, 2'b11};
        tbl[6]  = '{2'b00, 2'b11, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0,   32'h0, 2'b11, 2'b11};
        tbl[7]  = '{2'b00, 2'b11, 2'b00, 32'h40, 32'h80, 32'h0, 2'd1, 1'b1, 1'b0, 32'h80,  32'h0, 2'b11, 2'b11};
        tbl[8]  = '{2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h80,  32'h0, 2'b11, 2'b11};
        tbl[9]  = '{2'b01, 2'b10, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0,   32'h0, 2'b11, 2'b11};
        tbl[10] = '{2'b01, 2'b10, 2'b00, 32'h40, 32'h80, 32'h0, 2'd2, 1'b1, 1'b0, 32'h80,  32'h0, 2'b11, 2'b01};
        tbl[11] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h80,  32'h0, 2'b11, 2'b11};
        tbl[12] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0,   32'h0, 2'b11, 2'b11};
        tbl[13] = '{2'b01, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 2'd2, 1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 2'b11};
        tbl[14] = '{2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'h0, 2'd0, 1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 2'b11};
        tbl[15] = '{2'b00, 2'b10, 2'b10, 32'h40, 32'h80, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 32'h0,  32'h0,        2'b11, 2'b11};
        tbl[16] = '{2'b00, 2'b10, 2'b10, 32'h40, 32'h80, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 2'b11, 2'b01};
        tbl[17] = '{2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 32'h80, 32'hDEADBEEF, 2'b11, 2'b11};
        tbl[18] = '{2'b00, 2'b00, 2'b00, 32'h40, 32'h80, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 32'h0,  32'h0,        2'b11, 2'b11};

        clear_inputs();
        RST = 1'b1;
        model_reset();
        #3;
        model_check();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Idle: nothing requested for 10 cycles
        for (int c = 0; c < 10; c++) begin
            #2;
            model_check();
            chk("idle_ramREN", 32'(ramREN), 32'd0);
            chk("idle_waits", 32'({iwait, dwait}), 32'hF);
            tick();
        end

        // Directed vector table: fetch, pointer rotation, priority, write precedence
        for (int r = 0; r < 19; r++) begin
            iREN   = tbl[r].iren;
            dREN   = tbl[r].dren;
            dWEN   = tbl[r].dwen;
            daddr  = {tbl[r].da1, tbl[r].da0};
            dstore = {tbl[r].ds1, 32'h0};
            iaddr  = {32'h200, 32'h100};
            ramstate = tbl[r].rs;
            ramload  = $urandom;
            #2;
            chk($sformatf("vec%0d_ramREN", r), 32'(ramREN), 32'(tbl[r].ren));
            chk($sformatf("vec%0d_ramWEN", r), 32'(ramWEN), 32'(tbl[r].wen));
            chk($sformatf("vec%0d_ramaddr", r), ramaddr, tbl[r].addr);
            chk($sformatf("vec%0d_ramstore", r), ramstore, tbl[r].store);
            chk($sformatf("vec%0d_iwait", r), 32'(iwait), 32'(tbl[r].iw));
            chk($sformatf("vec%0d_dwait", r), 32'(dwait), 32'(tbl[r].dw));
            model_check();
            tick();
        end

        // Round-robin: both dcaches writing continuously, RAM always ACCESS
        dREN = 0; dWEN = 2'b11; iREN = 0;
        daddr = {32'hB0, 32'hA0}; ramstate = 2'd2;
        for (int c = 0; c < 12; c++) begin
            logic [1:0] e_dw;
            case (c % 6)
                1, 2:    e_dw = 2'b10;
                4, 5:    e_dw = 2'b01;
                default: e_dw = 2'b11;
            endcase
            #2;
            chk($sformatf("rr%0d_dwait", c), 32'(dwait), 32'(e_dw));
            model_check();
            tick();
        end

        // Error under a grant, then reset clears the sticky flag
        clear_inputs();
        tick();
        tick();
        dWEN = 2'b01; daddr = {32'h0, 32'h300}; dstore = {32'h0, 32'h55};
        #2; model_check(); tick();
        ramstate = 2'd3;
        #2;
        chk("err_dwait", 32'(dwait), 32'h3);
        model_check(); tick();
        #2;
        chk("err_sticky", 32'(bus_err), 32'd1);
        chk("err_hold_wen", 32'(ramWEN), 32'd1);
        chk("err_dwait2", 32'(dwait), 32'h3);
        model_check(); tick();
        do_reset();
        #2;
        chk("err_after_rst", 32'(bus_err), 32'd0);
        chk("idle_after_rst", 32'(ramWEN), 32'd0);
        model_check(); tick();

        // Random traffic with persistent requests and occasional resets
        for (int c = 0; c < 3000; c++) begin
            int rs;
            for (int i = 0; i < NCPU; i++) begin
                if ($urandom_range(0, 4) == 0) iREN[i] = ~iREN[i];
                if ($urandom_range(0, 4) == 0) dREN[i] = ~dREN[i];
                if ($urandom_range(0, 6) == 0) dWEN[i] = ~dWEN[i];
            end
            iaddr  = {$urandom, $urandom};
            daddr  = {$urandom, $urandom};
            dstore = {$urandom, $urandom};
            ramload = $urandom;
            rs = $urandom_range(0, 199);
            if (rs == 0)       ramstate = 2'd3;
            else if (rs < 40)  ramstate = 2'd0;
            else if (rs < 100) ramstate = 2'd1;
            else               ramstate = 2'd2;
            #2;
            model_check();
            tick();
            if (c % 500 == 499) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
